// File: rtl/fifo_ctl.sv
// fifo_ctl: single-clock FIFO controller driving the port-A write / port-B read pins of an 18-bit ram.
// Latency: a pushed word is poppable one edge later; popped data is on DOUT one cycle after the pop is accepted.
// Backpressure: PUSH on FULL and POP on EMPTY are dropped and recorded in the sticky OVF / UDF flags.
module fifo_ctl #(
   parameter int ADDRWID = 8,
   parameter int AE_LVL  = 4,
   parameter int AF_LVL  = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               PUSH,
   input  logic [17:0]        DIN,
   input  logic               POP,
   output logic [17:0]        DOUT,
   output logic               DOUT_VLD,
   output logic               EMPTY,
   output logic               FULL,
   output logic               AEMPTY,
   output logic               AFULL,
   output logic [ADDRWID:0]   LEVEL,
   output logic               OVF,
   output logic               UDF,
   output logic [ADDRWID-1:0] AA,
   output logic [ADDRWID-1:0] AB,
   output logic               CENA,
   output logic               WENA,
   output logic               CENB,
   output logic               WENB,
   output logic [1:0]         WENBA,
   output logic [1:0]         WENBB,
   output logic [17:0]        DA,
   input  logic [17:0]        QB
);

   // Pointers carry one extra wrap bit so that full (difference == DEPTH)
   // and empty (difference == 0) are distinguishable.
   typedef logic [ADDRWID:0] ptr_t;

   localparam ptr_t DEPTH_P = {1'b1, {ADDRWID{1'b0}}};
   localparam ptr_t AE_P    = ptr_t'(AE_LVL);
   localparam ptr_t AF_THR  = DEPTH_P - ptr_t'(AF_LVL);

   ptr_t wptr_q, wptr_d;
   ptr_t rptr_q, rptr_d;
   ptr_t level_d;
   logic empty_q, full_q, aempty_q, afull_q;
   logic ovf_q, udf_q;
   logic dout_vld_q;
   logic push_acc, pop_acc;

   // Acceptance looks only at the registered flags, so a concurrent pop
   // never rescues a push on FULL (and vice versa); reset blocks both.
   always_comb begin
      push_acc = PUSH & ~full_q  & ~RST;
      pop_acc  = POP  & ~empty_q & ~RST;
      wptr_d   = wptr_q + ptr_t'(push_acc);
      rptr_d   = rptr_q + ptr_t'(pop_acc);
      level_d  = wptr_d - rptr_d;
   end

   // Pointer, flag and sticky-error state; flags are precomputed from the next level.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         aempty_q   <= 1'b1;
         afull_q    <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         dout_vld_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         empty_q    <= (level_d == '0);
         full_q     <= (level_d == DEPTH_P);
         aempty_q   <= (level_d <= AE_P);
         afull_q    <= (level_d >= AF_THR);
         ovf_q      <= ovf_q | (PUSH & full_q);
         udf_q      <= udf_q | (POP & empty_q);
         dout_vld_q <= pop_acc;
      end
   end

   // Port A is write-only; occupied and free slots are disjoint so AA never equals a live AB read.
   assign AA    = wptr_q[ADDRWID-1:0];
   assign CENA  = ~push_acc;
   assign WENA  = ~push_acc;
   assign WENBA = 2'b00;
   assign DA    = DIN;

   // Port B is read-only.
   assign AB    = rptr_q[ADDRWID-1:0];
   assign CENB  = ~pop_acc;
   assign WENB  = 1'b1;
   assign WENBB = 2'b11;

   // QB passes straight through; DOUT_VLD marks the cycle after an accepted pop.
   assign DOUT     = QB;
   assign DOUT_VLD = dout_vld_q;

   assign LEVEL  = wptr_q - rptr_q;
   assign EMPTY  = empty_q;
   assign FULL   = full_q;
   assign AEMPTY = aempty_q;
   assign AFULL  = afull_q;
   assign OVF    = ovf_q;
   assign UDF    = udf_q;

endmodule

// File: tb/tb_fifo_ctl.sv
// tb_fifo_ctl: randomized bench for fifo_ctl with a queue-based reference model and a behavioural ram.
// Latency: expected pop data is queued at the accepting edge and compared at the following falling edge.
// Backpressure: the model applies the same full/empty rejection rules from its own occupancy count.
module tb_fifo_ctl;

   localparam int ADDRWID = 8;
   localparam int DEPTH   = 1 << ADDRWID;
   localparam int AE_LVL  = 4;
   localparam int AF_LVL  = 4;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               PUSH = 1'b0;
   logic [17:0]        DIN = '0;
   logic               POP = 1'b0;
   logic [17:0]        DOUT;
   logic               DOUT_VLD, EMPTY, FULL, AEMPTY, AFULL, OVF, UDF;
   logic [ADDRWID:0]   LEVEL;
   logic [ADDRWID-1:0] AA, AB;
   logic               CENA, WENA, CENB, WENB;
   logic [1:0]         WENBA, WENBB;
   logic [17:0]        DA;
   logic [17:0]        QB = '0;

   fifo_ctl #(.ADDRWID(ADDRWID), .AE_LVL(AE_LVL), .AF_LVL(AF_LVL)) dut (
      .CLK(CLK), .RST(RST), .PUSH(PUSH), .DIN(DIN), .POP(POP),
      .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .EMPTY(EMPTY), .FULL(FULL),
      .AEMPTY(AEMPTY), .AFULL(AFULL), .LEVEL(LEVEL), .OVF(OVF), .UDF(UDF),
      .AA(AA), .AB(AB), .CENA(CENA), .WENA(WENA), .CENB(CENB), .WENB(WENB),
      .WENBA(WENBA), .WENBB(WENBB), .DA(DA), .QB(QB)
   );

   always #5 CLK = ~CLK;

   // Behavioural ram: synchronous write on port A, synchronous read on port B.
   logic [17:0] mem [DEPTH];
   always @(posedge CLK) begin
      if (!CENA && !WENA) mem[AA] <= DA;
      if (!CENB) QB <= mem[AB];
   end

   // Reference model: contents as a plain queue, write count for the address.
   logic [17:0] m_q[$];
   logic [17:0] exp_q[$];
   int          m_wcnt = 0;
   int          m_rcnt = 0;
   bit          m_ovf = 0;
   bit          m_udf = 0;
   bit          m_vld = 0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   always @(posedge CLK) begin
      bit full_now, empty_now;
      full_now  = (m_q.size() == DEPTH);
      empty_now = (m_q.size() == 0);
      if (RST) begin
         m_q.delete();
         exp_q.delete();
         m_wcnt = 0;
         m_rcnt = 0;
         m_ovf  = 0;
         m_udf  = 0;
         m_vld  = 0;
      end else begin
         m_vld = 0;
         if (POP && !empty_now) begin
            exp_q.push_back(m_q.pop_front());
            m_rcnt++;
            m_vld = 1;
         end
         if (PUSH && !full_now) begin
            m_q.push_back(DIN);
            m_wcnt++;
         end
         if (PUSH && full_now)  m_ovf = 1;
         if (POP  && empty_now) m_udf = 1;
      end
   end

   // Monitor: status, ram pins and popped data, sampled mid-cycle.
   always @(negedge CLK) begin
      int  sz;
      bit  exp_push, exp_pop;
      sz       = m_q.size();
      exp_push = PUSH && (sz != DEPTH) && !RST;
      exp_pop  = POP && (sz != 0) && !RST;
      chk("level",  32'(LEVEL),  32'(sz));
      chk("empty",  32'(EMPTY),  32'(sz == 0));
      chk("full",   32'(FULL),   32'(sz == DEPTH));
      chk("aempty", 32'(AEMPTY), 32'(sz <= AE_LVL));
      chk("afull",  32'(AFULL),  32'(sz >= DEPTH - AF_LVL));
      chk("ovf",    32'(OVF),    32'(m_ovf));
      chk("udf",    32'(UDF),    32'(m_udf));
      chk("cena",   32'(CENA),   32'(!exp_push));
      chk("wena",   32'(WENA),   32'(!exp_push));
      chk("cenb",   32'(CENB),   32'(!exp_pop));
      chk("port_ro", {28'(0), WENB, WENBB, WENBA}, {28'(0), 1'b1, 2'b11, 2'b00});
      chk("da",     32'(DA),     32'(DIN));
      chk("aa",     32'(AA),     32'(m_wcnt % DEPTH));
      chk("ab",     32'(AB),     32'(m_rcnt % DEPTH));
      chk("dout_vld", 32'(DOUT_VLD), 32'(m_vld));
      if (DOUT_VLD === 1'b1) begin
         if (exp_q.size() == 0) chk("sb_has_entry", 32'(exp_q.size()), 32'd1);
         else chk("dout", 32'(DOUT), 32'(exp_q.pop_front()));
      end
   end

   task automatic cyc(input logic rst, input logic push, input logic pop, input logic [17:0] din);
      RST  = rst;
      PUSH = push;
      POP  = pop;
      DIN  = din;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Reset with both requests asserted: no ram enable may go low.
      cyc(1'b1, 1'b1, 1'b1, 18'h3FFFF);
      cyc(1'b1, 1'b1, 1'b1, 18'h3FFFF);

      // Fill to DEPTH with an incrementing pattern.
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 18'(i));

      // Overflow: rejected pushes, sticky OVF.
      cyc(1'b0, 1'b1, 1'b0, 18'h3FFFF);
      cyc(1'b0, 1'b0, 1'b0, 18'h0);

      // Push+pop while full: push rejected, pop accepted.
      cyc(1'b0, 1'b1, 1'b1, 18'h3FFFF);

      // Drain, then pop past empty with a concurrent push.
      for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b0, 1'b1, 18'h0);
      cyc(1'b0, 1'b1, 1'b1, 18'h12345);
      cyc(1'b0, 1'b0, 1'b1, 18'h0);
      cyc(1'b0, 1'b0, 1'b0, 18'h0);

      // Steady-state level 10 with simultaneous push/pop, pointers wrapping.
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 18'($urandom));
      for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 1'b1, 18'($urandom));

      // Random traffic with occasional mid-stream reset.
      for (int i = 0; i < 3000; i++) begin
         logic r, pu, po;
         r  = ($urandom_range(0, 299) == 0);
         pu = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 35));
         po = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 70));
         cyc(r, pu, po, 18'($urandom));
      end

      // Drain everything and let the last read data be checked.
      for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 1'b0, 1'b1, 18'h0);
      cyc(1'b0, 1'b0, 1'b0, 18'h0);
      @(negedge CLK);
      #1;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
